// File: rtl/dp_sram_pipelined.sv
// -----------------------------------------------------------------------------
// dp_sram_pipelined
//
// True dual-port SRAM model for on-chip data buffers. Both ports can read and
// write every cycle, with byte-lane write enables and a read pipeline of
// RD_LAT stages per port.
//
// State table (sweep controller)
//   state | meaning
//   IDLE  | normal operation, both ports accept requests
//   CLEAR | zero-fill sweep running, word[ptr] <= 0 each cycle, requests ignored
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   busy           high while the zero-fill sweep runs
//   port_x_en      request valid (x = a, b)
//   port_x_we      1 = write, 0 = read
//   port_x_be      byte-lane write enables
//   port_x_addr    word address
//   port_x_wdata   write data
//   port_x_rdata   read data, holds its value between strobes
//   port_x_rvalid  one-cycle strobe marking rdata valid
//   collision      one-cycle pulse: both ports wrote overlapping lanes of the
//                  same word in the previous cycle
//
// Timing
//   The memory word is sampled at the edge that accepts the read. It travels
//   through RD_LAT pipeline stages and lands in the output register, so
//   rdata/rvalid change RD_LAT edges after the request edge.
//
// Collision rules
//   Both ports writing one word: port A owns every lane it enables, lanes
//   enabled only on B take B data.
//   One port writing, the other reading the same word: the reader gets the
//   pre-write word (CROSS_BYPASS=0) or the post-write word merged per byte
//   enable (CROSS_BYPASS=1).
//
// Addresses at or beyond DEPTH drop writes and read back as zero.
// -----------------------------------------------------------------------------
module dp_sram_pipelined #(
  parameter int ADDR_W         = 15,
  parameter int DATA_W         = 16,
  parameter int DEPTH          = 1 << ADDR_W,
  parameter int RD_LAT         = 1,
  parameter int CROSS_BYPASS   = 0,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                busy,

  input  logic                port_a_en,
  input  logic                port_a_we,
  input  logic [DATA_W/8-1:0] port_a_be,
  input  logic [ADDR_W-1:0]   port_a_addr,
  input  logic [DATA_W-1:0]   port_a_wdata,
  output logic [DATA_W-1:0]   port_a_rdata,
  output logic                port_a_rvalid,

  input  logic                port_b_en,
  input  logic                port_b_we,
  input  logic [DATA_W/8-1:0] port_b_be,
  input  logic [ADDR_W-1:0]   port_b_addr,
  input  logic [DATA_W-1:0]   port_b_wdata,
  output logic [DATA_W-1:0]   port_b_rdata,
  output logic                port_b_rvalid,

  output logic                collision
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic [DATA_W-1:0]   mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Request qualification
  // ---------------------------------------------------------------------------
  logic               a_act, b_act;
  logic               a_in, b_in;
  logic               a_wr, b_wr;
  logic               a_rd, b_rd;
  logic               same_addr;
  logic [IDX_W-1:0]   a_idx, b_idx;
  logic [DATA_W-1:0]  a_old, b_old;
  logic [DATA_W-1:0]  a_rd_word, b_rd_word;
  logic               coll_nxt;

  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  always_comb begin
    a_act     = port_a_en && !busy && !rst;
    b_act     = port_b_en && !busy && !rst;
    a_in      = {1'b0, port_a_addr} < DEPTH_L;
    b_in      = {1'b0, port_b_addr} < DEPTH_L;
    a_idx     = port_a_addr[IDX_W-1:0];
    b_idx     = port_b_addr[IDX_W-1:0];
    a_wr      = a_act && port_a_we && a_in;
    b_wr      = b_act && port_b_we && b_in;
    a_rd      = a_act && !port_a_we;
    b_rd      = b_act && !port_b_we;
    same_addr = port_a_addr == port_b_addr;

    a_old = a_in ? mem[a_idx] : '0;
    b_old = b_in ? mem[b_idx] : '0;

    // Reader normally sees the word as it stood before this edge; with
    // bypass enabled, a same-word write on the other port is folded in.
    a_rd_word = a_old;
    b_rd_word = b_old;
    if (CROSS_BYPASS != 0) begin
      if (b_wr && same_addr) a_rd_word = merge_lanes(a_old, port_b_wdata, port_b_be);
      if (a_wr && same_addr) b_rd_word = merge_lanes(b_old, port_a_wdata, port_a_be);
    end

    coll_nxt = a_wr && b_wr && same_addr && (|(port_a_be & port_b_be));
  end

  // ---------------------------------------------------------------------------
  // Storage. B lanes are written first so a later A assignment to the same
  // lane takes priority. Contents are only cleared by the sweep.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[ptr] <= '0;
      end else begin
        for (int i = 0; i < BE_W; i++) begin
          if (b_wr && port_b_be[i]) mem[b_idx][8*i +: 8] <= port_b_wdata[8*i +: 8];
          if (a_wr && port_a_be[i]) mem[a_idx][8*i +: 8] <= port_a_wdata[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sweep controller
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      busy  <= (CLEAR_ON_RESET != 0);
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
        end
        CLEAR: begin
          if (ptr == LAST_IDX) begin
            state <= IDLE;
            busy  <= 1'b0;
            ptr   <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipelines
  // ---------------------------------------------------------------------------
  logic [RD_LAT-1:0]  a_pv, b_pv;
  logic [DATA_W-1:0]  a_pd [RD_LAT];
  logic [DATA_W-1:0]  b_pd [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      a_pv          <= '0;
      port_a_rvalid <= 1'b0;
      port_a_rdata  <= '0;
    end else begin
      a_pv[0] <= a_rd;
      a_pd[0] <= a_rd_word;
      for (int i = 1; i < RD_LAT; i++) begin
        a_pv[i] <= a_pv[i-1];
        a_pd[i] <= a_pd[i-1];
      end
      port_a_rvalid <= a_pv[RD_LAT-1];
      if (a_pv[RD_LAT-1]) port_a_rdata <= a_pd[RD_LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_pv          <= '0;
      port_b_rvalid <= 1'b0;
      port_b_rdata  <= '0;
    end else begin
      b_pv[0] <= b_rd;
      b_pd[0] <= b_rd_word;
      for (int i = 1; i < RD_LAT; i++) begin
        b_pv[i] <= b_pv[i-1];
        b_pd[i] <= b_pd[i-1];
      end
      port_b_rvalid <= b_pv[RD_LAT-1];
      if (b_pv[RD_LAT-1]) port_b_rdata <= b_pd[RD_LAT-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Collision flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) collision <= 1'b0;
    else     collision <= coll_nxt;
  end

endmodule

// File: tb/tb_dp_sram_pipelined.sv
// Bench for dp_sram_pipelined. Two instances share the clock:
//   u0: DEPTH=16, RD_LAT=2, CROSS_BYPASS=0, CLEAR_ON_RESET=1
//   u1: DEPTH=128, RD_LAT=3, CROSS_BYPASS=1, CLEAR_ON_RESET=0
// Read requests push their expected word and arrival cycle into a queue per
// instance/port; the monitor pops on every rvalid.
module tb_dp_sram_pipelined;

  logic        clk;
  logic        rst      [2];
  logic        busy     [2];
  logic        coll     [2];
  logic        en       [2][2];
  logic        we       [2][2];
  logic [1:0]  be       [2][2];
  logic [7:0]  addr     [2][2];
  logic [15:0] wdata    [2][2];
  logic [15:0] rdata    [2][2];
  logic        rvalid   [2][2];

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t  sq [4][$];
  string qname [4] = '{"u0_a", "u0_b", "u1_a", "u1_b"};

  int cyc;
  int n_pass;
  int n_total;
  int cnt;

  dp_sram_pipelined #(
    .ADDR_W(8), .DATA_W(16), .DEPTH(16), .RD_LAT(2),
    .CROSS_BYPASS(0), .CLEAR_ON_RESET(1)
  ) u0 (
    .clk(clk), .rst(rst[0]), .busy(busy[0]),
    .port_a_en(en[0][0]), .port_a_we(we[0][0]), .port_a_be(be[0][0]),
    .port_a_addr(addr[0][0]), .port_a_wdata(wdata[0][0]),
    .port_a_rdata(rdata[0][0]), .port_a_rvalid(rvalid[0][0]),
    .port_b_en(en[0][1]), .port_b_we(we[0][1]), .port_b_be(be[0][1]),
    .port_b_addr(addr[0][1]), .port_b_wdata(wdata[0][1]),
    .port_b_rdata(rdata[0][1]), .port_b_rvalid(rvalid[0][1]),
    .collision(coll[0])
  );

  dp_sram_pipelined #(
    .ADDR_W(8), .DATA_W(16), .DEPTH(128), .RD_LAT(3),
    .CROSS_BYPASS(1), .CLEAR_ON_RESET(0)
  ) u1 (
    .clk(clk), .rst(rst[1]), .busy(busy[1]),
    .port_a_en(en[1][0]), .port_a_we(we[1][0]), .port_a_be(be[1][0]),
    .port_a_addr(addr[1][0]), .port_a_wdata(wdata[1][0]),
    .port_a_rdata(rdata[1][0]), .port_a_rvalid(rvalid[1][0]),
    .port_b_en(en[1][1]), .port_b_we(we[1][1]), .port_b_be(be[1][1]),
    .port_b_addr(addr[1][1]), .port_b_wdata(wdata[1][1]),
    .port_b_rdata(rdata[1][1]), .port_b_rvalid(rvalid[1][1]),
    .collision(coll[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h (cyc %0d)", nm, act, exp, cyc);
  endtask

  function automatic int lat(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        en[i][p]    = 1'b0;
        we[i][p]    = 1'b0;
        be[i][p]    = 2'b00;
        addr[i][p]  = 8'h00;
        wdata[i][p] = 16'h0000;
      end
    end
  endtask

  task automatic go();
    tick();
    clr();
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input int i, input int p, input logic [7:0] a,
                    input logic [15:0] d, input logic [1:0] b);
    en[i][p]    = 1'b1;
    we[i][p]    = 1'b1;
    be[i][p]    = b;
    addr[i][p]  = a;
    wdata[i][p] = d;
  endtask

  task automatic rd(input int i, input int p, input logic [7:0] a,
                    input logic [15:0] exp, input bit want = 1'b1);
    exp_t e;
    en[i][p]   = 1'b1;
    we[i][p]   = 1'b0;
    addr[i][p] = a;
    if (want) begin
      e.data = exp;
      e.cyc  = cyc + 1 + lat(i);
      sq[i*2+p].push_back(e);
    end
  endtask

  // Monitor: pops one expectation per rvalid, flags strobes that arrive
  // unrequested or never arrive.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (rvalid[k/2][k%2]) begin
        if (sq[k].size() == 0) begin
          n_total++;
          $display("FAIL %s_unexpected_rvalid actual rdata=%h expected no strobe (cyc %0d)",
                   qname[k], rdata[k/2][k%2], cyc);
        end else begin
          e = sq[k].pop_front();
          check({qname[k], "_rdata"}, 32'(rdata[k/2][k%2]), 32'(e.data));
          check({qname[k], "_latency"}, cyc, e.cyc);
        end
      end else if (sq[k].size() != 0 && sq[k][0].cyc <= cyc) begin
        n_total++;
        $display("FAIL %s_missing_rvalid actual none expected strobe at cyc %0d (cyc %0d)",
                 qname[k], sq[k][0].cyc, cyc);
        void'(sq[k].pop_front());
      end
    end
  end

  initial begin
    cyc     = 0;
    n_pass  = 0;
    n_total = 0;
    clr();
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    tick();
    tick();

    // ---------------- reset state ----------------
    check("u0_busy_in_reset",   32'(busy[0]), 32'd1);
    check("u1_busy_in_reset",   32'(busy[1]), 32'd0);
    check("u0_rvalid_in_reset", 32'(rvalid[0][0]), 32'd0);
    check("u0_rdata_in_reset",  32'(rdata[0][0]), 32'd0);
    check("u1_rdata_in_reset",  32'(rdata[1][1]), 32'd0);
    check("u1_coll_in_reset",   32'(coll[1]), 32'd0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // ---------------- u0: sweep length, write during busy ----------------
    cnt = 0;
    while (busy[0] && cnt < 100) begin
      cnt++;
      if (cnt == 16) wr(0, 0, 8'h03, 16'hDEAD, 2'b11);
      go();
    end
    check("u0_sweep_cycles", cnt, 16);
    for (int a = 0; a < 16; a++) begin
      rd(0, 0, 8'(a), 16'h0000);
      go();
    end
    drain(4);

    // ---------------- u0: out-of-range address ----------------
    wr(0, 0, 8'h13, 16'h1234, 2'b11);
    go();
    rd(0, 0, 8'h13, 16'h0000);
    rd(0, 1, 8'hFF, 16'h0000);
    go();
    rd(0, 0, 8'h03, 16'h0000);
    go();

    // ---------------- u0: write/read same word, no bypass ----------------
    wr(0, 0, 8'h04, 16'h0F0F, 2'b11);
    go();
    wr(0, 0, 8'h04, 16'hF0F0, 2'b11);
    rd(0, 1, 8'h04, 16'h0F0F);
    go();
    rd(0, 0, 8'h04, 16'hF0F0);
    rd(0, 1, 8'h04, 16'hF0F0);
    go();
    drain(5);
    check("u0_rdata_hold", 32'(rdata[0][0]), 32'h0000F0F0);

    // ---------------- u0: reset mid-read, then mid-sweep ----------------
    wr(0, 0, 8'h0C, 16'hAAAA, 2'b11);
    go();
    rd(0, 0, 8'h04, 16'h0000, 1'b0);
    go();
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    check("u0_rdata_after_flush", 32'(rdata[0][0]), 32'd0);
    check("u0_busy_after_flush",  32'(busy[0]), 32'd1);
    drain(8);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    cnt = 0;
    while (busy[0] && cnt < 100) begin
      cnt++;
      go();
    end
    check("u0_restart_sweep_cycles", cnt, 16);
    check("u0_rdata_zero_after_sweep", 32'(rdata[0][0]), 32'd0);
    rd(0, 0, 8'h0C, 16'h0000);
    go();

    // ---------------- u1: latency and back-to-back ----------------
    wr(1, 0, 8'h05, 16'hBEEF, 2'b11);
    go();
    rd(1, 0, 8'h05, 16'hBEEF);
    go();
    wr(1, 0, 8'h06, 16'h1111, 2'b11);
    wr(1, 1, 8'h07, 16'h2222, 2'b11);
    go();
    rd(1, 0, 8'h05, 16'hBEEF); go();
    rd(1, 0, 8'h06, 16'h1111); go();
    rd(1, 0, 8'h07, 16'h2222); go();
    rd(1, 0, 8'h05, 16'hBEEF); go();

    // ---------------- u1: byte enables ----------------
    wr(1, 0, 8'h10, 16'h1234, 2'b11); go();
    wr(1, 0, 8'h10, 16'hABCD, 2'b10); go();
    rd(1, 0, 8'h10, 16'hAB34);        go();
    wr(1, 0, 8'h10, 16'h5555, 2'b00); go();
    rd(1, 0, 8'h10, 16'hAB34);        go();
    wr(1, 1, 8'h10, 16'h00EE, 2'b01); go();
    rd(1, 1, 8'h10, 16'hABEE);        go();

    // ---------------- u1: dual write collisions ----------------
    wr(1, 0, 8'h20, 16'h1111, 2'b11);
    wr(1, 1, 8'h20, 16'h2222, 2'b11);
    go();
    check("u1_coll_full_overlap", 32'(coll[1]), 32'd1);
    tick();
    check("u1_coll_one_cycle", 32'(coll[1]), 32'd0);
    rd(1, 0, 8'h20, 16'h1111); go();
    wr(1, 0, 8'h20, 16'h1111, 2'b01);
    wr(1, 1, 8'h20, 16'h2222, 2'b10);
    go();
    check("u1_coll_disjoint", 32'(coll[1]), 32'd0);
    rd(1, 0, 8'h20, 16'h2211); go();
    wr(1, 0, 8'h20, 16'h00AA, 2'b01);
    wr(1, 1, 8'h20, 16'hBBCC, 2'b11);
    go();
    check("u1_coll_partial", 32'(coll[1]), 32'd1);
    rd(1, 1, 8'h20, 16'hBBAA); go();

    // ---------------- u1: cross write/read with bypass ----------------
    wr(1, 0, 8'h40, 16'h0F0F, 2'b11); go();
    wr(1, 0, 8'h40, 16'hF0F0, 2'b11);
    rd(1, 1, 8'h40, 16'hF0F0);
    go();
    wr(1, 0, 8'h40, 16'h1234, 2'b01);
    rd(1, 1, 8'h40, 16'hF034);
    go();
    wr(1, 1, 8'h40, 16'h5600, 2'b10);
    rd(1, 0, 8'h40, 16'h5634);
    go();
    rd(1, 0, 8'h40, 16'h5634);
    rd(1, 1, 8'h40, 16'h5634);
    go();

    // ---------------- u1: out-of-range write must not alias ----------------
    wr(1, 1, 8'h90, 16'hFFFF, 2'b11); go();
    rd(1, 1, 8'h90, 16'h0000);        go();
    rd(1, 0, 8'h10, 16'hABEE);        go();
    drain(8);

    for (int k = 0; k < 4; k++) check({qname[k], "_queue_empty"}, sq[k].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dp_sram_pipelined.md
Name: dp_sram_pipelined

Overview:
- Parametrised true dual-port SRAM macro model for on-chip data buffers. It generalises the existing 15-bit-address, 16-bit-data, port-A-write / port-B-read buffer.
- Both ports read and write.
- Adds byte-lane write enables, a configurable read pipeline with valid strobes, deterministic cross-port collision handling and an optional zero-fill sweep after reset.
- Sits between accelerator datapath masters and buffer storage.

Parameters:
- ADDR_W, 15, address width per port.
- DATA_W, 16, data width; multiple of 8.
- DEPTH, 1<<ADDR_W, number of words; DEPTH <= 2^ADDR_W.
- RD_LAT, 1, read latency in cycles; legal range 1..4.
- CROSS_BYPASS, 0, same-address cross-port write/read result: 0 = reader sees old data, 1 = reader sees newly written data.
- CLEAR_ON_RESET, 0, 1 = zero-fill all DEPTH words after reset.

Ports:
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- busy  out  1  high while zero-fill sweep runs; requests ignored
- port_a_en  in  1  port A request valid
- port_a_we  in  1  1 = write, 0 = read (qualified by en)
- port_a_be  in  DATA_W/8  byte-lane write enables
- port_a_addr  in  ADDR_W  word address
- port_a_wdata  in  DATA_W  write data
- port_a_rdata  out  DATA_W  read data
- port_a_rvalid  out  1  one-cycle strobe, rdata valid
- port_b_en, port_b_we, port_b_be, port_b_addr, port_b_wdata, port_b_rdata, port_b_rvalid: same as port A
- collision  out  1  pulse: both ports wrote the same address in the same cycle

Behaviour:
- Reset (rst=1 at edge): all rvalid=0, rdata=0, collision=0, read pipelines flushed, busy=CLEAR_ON_RESET, sweep pointer=0. Memory contents are not reset except by the sweep.
- Requests are ignored while rst=1 or busy=1: no write, no rvalid, no collision.
- FSM has two states, IDLE and CLEAR.
  - rst moves the FSM to CLEAR if CLEAR_ON_RESET=1, else to IDLE.
  - In CLEAR, word[ptr] is written to 0 and ptr increments each cycle.
  - At ptr==DEPTH-1, the last word is written and the FSM goes to IDLE; busy falls on the next edge.
  - The sweep takes exactly DEPTH cycles.
  - rst asserted mid-sweep restarts the sweep at ptr=0.
- Write (en=1, we=1): for each lane i with be[i]=1, word[addr][8i+7:8i] takes wdata at the edge. be=0 writes nothing.
  - No rvalid is produced for a write.
- Read (en=1, we=0): data for addr is sampled at the request edge. rdata/rvalid appear RD_LAT edges later; rvalid is a single-cycle pulse per read.
  - Back-to-back reads are accepted every cycle: fully pipelined, throughput 1 per port per cycle.
  - rdata holds its last value when rvalid=0.
- addr >= DEPTH: write dropped, read returns 0 with normal rvalid timing.
- Same-cycle, same-address, both ports writing:
  - Port A wins on every lane enabled on A.
  - Lanes enabled only on B take B data.
  - collision=1 on the next cycle for exactly one cycle, only if the enabled lane sets overlap.
- Same-cycle, same-address, one port writing and the other reading:
  - CROSS_BYPASS=0: the reader gets the pre-write word.
  - CROSS_BYPASS=1: the reader gets the post-write word, merged per byte enable.
- Both ports reading the same address: both return identical data.
- Reset mid-read: pipelines flush and no rvalid is issued for reads accepted before reset.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=16: pulse rst one cycle -> busy=1 for exactly 16 cycles. Then A reads all 16 addresses -> all 0x0000. A write during busy to addr 3 -> no effect.
- RD_LAT=3: A writes 0xBEEF @0x0005; next cycle A reads 0x0005 -> rvalid exactly 3 cycles after the read edge, rdata=0xBEEF. Then 4 back-to-back reads -> 4 consecutive rvalid pulses in order.
- Byte enables: word @0x10=0x1234; A writes 0xABCD with be=2'b10 -> read gives 0xAB34. be=2'b00 -> unchanged.
- Dual write collision @0x20: A wdata=0x1111 be=11, B wdata=0x2222 be=11 -> word=0x1111, collision high one cycle. Repeat with A be=01, B be=10 -> word=0x2211, collision stays 0.
- Cross read/write @0x40 (old 0x0F0F): A writes 0xF0F0 while B reads same cycle -> B gets 0x0F0F with CROSS_BYPASS=0, 0xF0F0 with CROSS_BYPASS=1.
- Reset mid-sweep at ptr=8 and mid-read (RD_LAT=2) -> sweep restarts at ptr=0 and takes full DEPTH cycles; the pending read produces no rvalid; rdata=0.
